srb_seq_ctrl: RTL and testbench

Sequencer and latency monitor that drives a chain of N SRB cells and consumes the output of the last cell. It accepts a toggle pattern over a valid/ready handshake and launches one run. A run holds the chain's `start`, injects a single-cycle pulse on the chain's first input, and measures the cycles until the pulse appears at the chain output. The measured latency, plus a timeout flag, is returned over a second valid/ready handshake.

---
 rtl/srb_seq_ctrl.sv | 111 +++++++++++
 tb/tb_srb_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/srb_seq_ctrl.sv
// srb_seq_ctrl: launches one pulse through an SRB chain and measures its latency.
// Optional timeout abort is selected by defining SRB_SEQ_TIMEOUT_EN.
module srb_seq_ctrl #(
    parameter int N       = 12,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [N-1:0]     cfg_toggle,
    output logic             srb_start,
    output logic [N-1:0]     srb_toggle,
    output logic             srb_in,
    input  logic             chain_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_latency,
    output logic             res_timeout,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FIRE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef SRB_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cfg_ready   <= 1'b1;
            srb_start   <= 1'b0;
            srb_in      <= 1'b0;
            srb_toggle  <= '0;
            res_valid   <= 1'b0;
            res_latency <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        srb_toggle  <= cfg_toggle;
                        res_timeout <= 1'b0;
                        cfg_ready   <= 1'b0;
                        busy        <= 1'b1;
                        srb_start   <= 1'b1;
                        state       <= S_ARM;
                    end
                end
                S_ARM: begin
                    srb_in <= 1'b1;
                    state  <= S_FIRE;
                end
                S_FIRE: begin
                    srb_in <= 1'b0;
                    cnt    <= CNT_W'(1);
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // A pulse arriving on the timeout edge still counts as a hit
                    if (chain_out) begin
                        res_latency <= cnt;
                        res_valid   <= 1'b1;
                        srb_start   <= 1'b0;
                        state       <= S_DONE;
`ifdef SRB_SEQ_TIMEOUT_EN
                    end else if (cnt == TMO) begin
                        res_latency <= TMO;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        srb_start   <= 1'b0;
                        state       <= S_DONE;
`endif
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srb_seq_ctrl.sv
// tb_srb_seq_ctrl: randomized runs through a modelled SRB chain with a
// scoreboard of expected latencies checked by an independent monitor.
module tb_srb_seq_ctrl;

    localparam int N     = 12;
    localparam int CNT_W = 8;
    localparam int TMO   = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [N-1:0]     cfg_toggle;
    logic             srb_start;
    logic [N-1:0]     srb_toggle;
    logic             srb_in;
    logic             chain_out;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_latency;
    logic             res_timeout;
    logic             busy;

    logic [N-1:0] chain_q;
    logic         force_hi;
    logic         force_lo;

    typedef struct {
        int lat;
        bit to;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    srb_seq_ctrl #(.N(N), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_toggle(cfg_toggle),
        .srb_start(srb_start),
        .srb_toggle(srb_toggle),
        .srb_in(srb_in),
        .chain_out(chain_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_latency(res_latency),
        .res_timeout(res_timeout),
        .busy(busy)
    );

    // Environment: chain of one-cycle cells, cell i shortcuts to srb_in when toggled
    always @(posedge clk) begin
        if (!srb_start) begin
            chain_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i == 0 || srb_toggle[i])
                    chain_q[i] <= srb_in;
                else
                    chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign chain_out = force_hi | (chain_q[N-1] & ~force_lo);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_lat(input logic [N-1:0] t);
        for (int i = N - 1; i >= 0; i--)
            if (t[i]) return N - i;
        return N;
    endfunction

    // Monitor: every completed result handshake must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_latency", 32'(res_latency), 32'(e.lat));
                check("res_timeout", 32'(res_timeout), 32'(e.to));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [N-1:0] tog, input bit arm_hi);
        int b;
        b = 0;
        while (!cfg_ready && b < 10) begin
            tick();
            b++;
        end
        check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        cfg_toggle = tog;
        cfg_valid  = 1'b1;
        force_hi   = arm_hi;
        tick();
        cfg_valid  = 1'b0;
        cfg_toggle = N'($urandom);
        check("arm_start", 32'(srb_start), 32'd1);
        check("arm_in", 32'(srb_in), 32'd0);
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_cfg_ready", 32'(cfg_ready), 32'd0);
        check("arm_toggle", 32'(srb_toggle), 32'(tog));
        tick();
        check("fire_in", 32'(srb_in), 32'd1);
        check("fire_start", 32'(srb_start), 32'd1);
        tick();
        force_hi = 1'b0;
        check("wait_in", 32'(srb_in), 32'd0);
    endtask

    task automatic run(input logic [N-1:0] tog, input int hold,
                       input bit arm_hi, input bit lo, input int hi_at,
                       input int exp_lat, input bit exp_to);
        exp_t e;
        int   b;
        logic [CNT_W-1:0] lat0;
        e.lat = exp_lat;
        e.to  = exp_to;
        exp_q.push_back(e);
        res_ready = (hold == 0);
        force_lo  = lo;
        launch(tog, arm_hi);
        if (hi_at > 0) begin
            repeat (hi_at - 1) tick();
            force_hi = 1'b1;
        end
        b = 0;
        while (!res_valid && b < 400) begin
            tick();
            b++;
        end
        force_hi = 1'b0;
        force_lo = 1'b0;
        check("res_valid_seen", 32'(res_valid), 32'd1);
        if (res_valid) begin
            lat0 = res_latency;
            for (int k = 0; k < hold; k++) begin
                cfg_valid  = 1'b1;
                cfg_toggle = ~tog;
                tick();
                check("hold_valid", 32'(res_valid), 32'd1);
                check("hold_latency", 32'(res_latency), 32'(lat0));
                check("hold_toggle", 32'(srb_toggle), 32'(tog));
                check("hold_cfg_ready", 32'(cfg_ready), 32'd0);
                check("hold_start", 32'(srb_start), 32'd0);
            end
            cfg_valid = 1'b0;
            res_ready = 1'b1;
            tick();
            check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
            check("idle_res_valid", 32'(res_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
        check({tag, "_start"}, 32'(srb_start), 32'd0);
        check({tag, "_in"}, 32'(srb_in), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_toggle"}, 32'(srb_toggle), 32'd0);
        check({tag, "_latency"}, 32'(res_latency), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int seen;
        logic [N-1:0] tog;
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_toggle = '0;
        res_ready  = 1'b1;
        force_hi   = 1'b0;
        force_lo   = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst = 1'b0;

        run(12'h000, 0, 0, 0, 0, 12, 0);
        run(12'h200, 0, 0, 0, 0, 3, 0);
        run(12'h800, 0, 0, 0, 0, 1, 0);
        run(12'h010, 5, 0, 0, 0, 8, 0);
        run(12'h000, 0, 1, 0, 0, 12, 0);

`ifdef SRB_SEQ_TIMEOUT_EN
        run(12'h000, 0, 0, 1, 0, TMO, 1);
        run(12'h000, 2, 0, 1, TMO, TMO, 0);
`else
        run(12'h000, 0, 0, 1, 5, 5, 0);
        run(12'h000, 1, 0, 1, 300, 255, 0);
`endif

        // Mid-run reset at WAIT count 5: no result may follow
        res_ready = 1'b1;
        launch(12'h000, 0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midrst");
        seen = 0;
        repeat (20) begin
            tick();
            if (res_valid) seen = 1;
        end
        check("midrst_no_result", 32'(seen), 32'd0);

        for (int r = 0; r < 12; r++) begin
            idx = $urandom_range(0, N);
            if (idx == N) begin
                tog = '0;
            end else begin
                tog = N'(1 << idx) | (N'($urandom) & N'((1 << idx) - 1));
            end
            run(tog, $urandom_range(0, 3), 0, 0, 0, model_lat(tog), 0);
        end

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
